// File: rtl/botoes_pkg.sv
// Shared definitions for the stopwatch push-button conditioner: per-key FSM
// state encoding, channel indices and the debounce counter width helper.
package botoes_pkg;

   typedef enum logic [1:0] {
      SOLTO          = 2'd0,
      CONFIRMA_PRESS = 2'd1,
      PRESSIONADO    = 2'd2,
      CONFIRMA_SOLTA = 2'd3
   } estado_t;

   localparam int CONTA    = 0;
   localparam int PAUSA    = 1;
   localparam int PARA     = 2;
   localparam int N_CANAIS = 3;

   // A one-cycle debounce still needs a 1-bit counter to keep widths legal.
   function automatic int largura_cnt(input int ciclos);
      return (ciclos > 1) ? $clog2(ciclos) : 1;
   endfunction

endpackage

// File: rtl/debounce_canal.sv
// One key channel: 2-FF synchroniser, stability counter and press/release FSM.
// Emits a registered single-cycle press_ev on a confirmed press only.
module debounce_canal
   import botoes_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic press_ev,
   output logic level
);

   localparam int            CW       = largura_cnt(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] ULTIMO   = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic          RAW_SOLTO = ACTIVE_LOW;

   logic          sync_a;
   logic          sync_b;
   logic          s;
   estado_t       estado;
   estado_t       estado_prox;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_prox;
   logic          press_prox;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_a <= RAW_SOLTO;
         sync_b <= RAW_SOLTO;
      end else begin
         sync_a <= btn;
         sync_b <= sync_a;
      end
   end

   // s is 1 while the key is pressed, regardless of board polarity.
   assign s = sync_b ^ RAW_SOLTO;

   always_ff @(posedge clk) begin
      if (reset) begin
         estado   <= SOLTO;
         cnt      <= '0;
         press_ev <= 1'b0;
      end else begin
         estado   <= estado_prox;
         cnt      <= cnt_prox;
         press_ev <= press_prox;
      end
   end

   always_comb begin
      estado_prox = estado;
      cnt_prox    = cnt;
      press_prox  = 1'b0;
      case (estado)
         SOLTO: begin
            if (s) begin
               estado_prox = CONFIRMA_PRESS;
               cnt_prox    = '0;
            end
         end
         CONFIRMA_PRESS: begin
            if (!s) begin
               estado_prox = SOLTO;
            end else if (cnt == ULTIMO) begin
               estado_prox = PRESSIONADO;
               press_prox  = 1'b1;
            end else begin
               cnt_prox = cnt + CW'(1);
            end
         end
         PRESSIONADO: begin
            if (!s) begin
               estado_prox = CONFIRMA_SOLTA;
               cnt_prox    = '0;
            end
         end
         CONFIRMA_SOLTA: begin
            if (s) begin
               estado_prox = PRESSIONADO;
            end else if (cnt == ULTIMO) begin
               estado_prox = SOLTO;
            end else begin
               cnt_prox = cnt + CW'(1);
            end
         end
         default: begin
            estado_prox = SOLTO;
            cnt_prox    = '0;
         end
      endcase
   end

   // The key still counts as held while its release is being confirmed.
   assign level = (estado == PRESSIONADO) || (estado == CONFIRMA_SOLTA);

endmodule

// File: rtl/condicionador_botoes.sv
// Stopwatch key conditioner: three debounced channels, fixed-priority
// arbitration para > pausa > conta, and registered pulses/levels.
module condicionador_botoes
   import botoes_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_conta,
   input  logic       btn_pausa,
   input  logic       btn_para,
   output logic       conta,
   output logic       pausa,
   output logic       para,
   output logic [2:0] nivel
);

   logic [N_CANAIS-1:0] raw;
   logic [N_CANAIS-1:0] ev;
   logic [N_CANAIS-1:0] lvl;
   logic [N_CANAIS-1:0] grant;

   assign raw[CONTA] = btn_conta;
   assign raw[PAUSA] = btn_pausa;
   assign raw[PARA]  = btn_para;

   for (genvar i = 0; i < N_CANAIS; i++) begin : g_canal
      debounce_canal #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .ACTIVE_LOW     (ACTIVE_LOW)
      ) u_canal (
         .clk     (clk),
         .reset   (reset),
         .btn     (raw[i]),
         .press_ev(ev[i]),
         .level   (lvl[i])
      );
   end

   // Losing same-cycle events are dropped so the FSM sees one command at most.
   always_comb begin
      grant = '0;
      if (ev[PARA]) begin
         grant[PARA] = 1'b1;
      end else if (ev[PAUSA]) begin
         grant[PAUSA] = 1'b1;
      end else if (ev[CONTA]) begin
         grant[CONTA] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         conta <= 1'b0;
         pausa <= 1'b0;
         para  <= 1'b0;
         nivel <= 3'b000;
      end else begin
         conta <= grant[CONTA];
         pausa <= grant[PAUSA];
         para  <= grant[PARA];
         nivel <= lvl;
      end
   end

endmodule

// File: tb/tb_condicionador_botoes.sv
// Self-checking bench for condicionador_botoes with DEBOUNCE_CYCLES=4 and
// active-low keys; expected pulses are queued as {cycle, para, pausa, conta}.
module tb_condicionador_botoes;

   localparam int D = 4;
   localparam int W = 19;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_conta;
   logic       btn_pausa;
   logic       btn_para;
   logic       conta;
   logic       pausa;
   logic       para;
   logic [2:0] nivel;

   int ciclo = 0;
   int n_tests = 0;
   int n_fail = 0;
   logic [W-1:0] exp_q[$];

   condicionador_botoes #(
      .DEBOUNCE_CYCLES(D),
      .ACTIVE_LOW     (1'b1)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .btn_conta(btn_conta),
      .btn_pausa(btn_pausa),
      .btn_para (btn_para),
      .conta    (conta),
      .pausa    (pausa),
      .para     (para),
      .nivel    (nivel)
   );

   always #5 clk = ~clk;

   always @(posedge clk) ciclo <= ciclo + 1;

   // Scoreboard: every pulse seen must match the oldest queued expectation.
   always @(negedge clk) begin
      logic [W-1:0] obs;
      logic [W-1:0] e;
      if (!reset && ((conta | pausa | para) !== 1'b0)) begin
         obs = {ciclo[15:0], para, pausa, conta};
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse cycle=%0d got para/pausa/conta=%b expected none",
                     ciclo, {para, pausa, conta});
         end else begin
            e = exp_q.pop_front();
            if (obs !== e) begin
               n_fail++;
               $display("FAIL pulse cycle/value got %0d/%b expected %0d/%b",
                        obs[W-1:3], obs[2:0], e[W-1:3], e[2:0]);
            end
         end
      end
   end

   task automatic expect_pulse(input int cyc, input logic [2:0] v);
      exp_q.push_back({cyc[15:0], v});
   endtask

   task automatic check_nivel(input string nome, input logic [2:0] esperado);
      n_tests++;
      if (nivel !== esperado) begin
         n_fail++;
         $display("FAIL %s nivel got %b expected %b (cycle %0d)", nome, nivel, esperado, ciclo);
      end
   endtask

   task automatic check_queue_empty(input string nome);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s missing_pulses got %0d pending expected 0", nome, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      btn_conta = 1'b1;
      btn_pausa = 1'b1;
      btn_para  = 1'b1;
      idle(3);
      n_tests++;
      if ({conta, pausa, para, nivel} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_outputs got %b expected 000000", {conta, pausa, para, nivel});
      end
      reset = 1'b0;
      idle(10);
      check_nivel("reset_idle", 3'b000);
   endtask

   task automatic test_clean_press();
      int base;
      @(negedge clk);
      btn_conta = 1'b0;
      base = ciclo;
      expect_pulse(base + D + 4, 3'b001);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         check_nivel("clean_press_hold", (k >= D + 4) ? 3'b001 : 3'b000);
      end
      btn_conta = 1'b1;
      base = ciclo;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         check_nivel("clean_press_release", (k >= D + 4) ? 3'b000 : 3'b001);
      end
      check_queue_empty("clean_press");
   endtask

   task automatic test_bounce();
      int base;
      @(negedge clk);
      btn_para = 1'b0;
      base = ciclo;
      expect_pulse(base + 12, 3'b100);
      idle(3);
      btn_para = 1'b1;
      idle(1);
      btn_para = 1'b0;
      idle(16);
      check_nivel("bounce_hold", 3'b100);
      btn_para = 1'b1;
      idle(12);
      check_nivel("bounce_release", 3'b000);
      check_queue_empty("bounce");
   endtask

   task automatic test_glitch();
      @(negedge clk);
      btn_pausa = 1'b0;
      idle(2);
      btn_pausa = 1'b1;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         check_nivel("glitch", 3'b000);
      end
      check_queue_empty("glitch");
   endtask

   task automatic test_simultaneous();
      int base;
      @(negedge clk);
      btn_conta = 1'b0;
      btn_para  = 1'b0;
      base = ciclo;
      expect_pulse(base + D + 4, 3'b100);
      idle(10);
      check_nivel("simultaneous_hold", 3'b101);
      btn_conta = 1'b1;
      btn_para  = 1'b1;
      idle(12);
      check_nivel("simultaneous_release", 3'b000);
      check_queue_empty("simultaneous");
   endtask

   task automatic test_pausa_over_conta();
      int base;
      @(negedge clk);
      btn_conta = 1'b0;
      btn_pausa = 1'b0;
      base = ciclo;
      expect_pulse(base + D + 4, 3'b010);
      idle(10);
      check_nivel("pausa_conta_hold", 3'b011);
      btn_conta = 1'b1;
      btn_pausa = 1'b1;
      idle(12);
      check_nivel("pausa_conta_release", 3'b000);
      check_queue_empty("pausa_over_conta");
   endtask

   task automatic test_hold_release();
      int base;
      @(negedge clk);
      btn_conta = 1'b0;
      base = ciclo;
      expect_pulse(base + D + 4, 3'b001);
      idle(100);
      check_nivel("hold_long", 3'b001);
      btn_conta = 1'b1;
      idle(1);
      btn_conta = 1'b0;
      idle(1);
      btn_conta = 1'b1;
      idle(D + 3);
      check_nivel("hold_bounce_not_yet_released", 3'b001);
      idle(20 - (D + 3));
      check_nivel("hold_idle", 3'b000);
      btn_conta = 1'b0;
      base = ciclo;
      expect_pulse(base + D + 4, 3'b001);
      idle(20);
      check_nivel("hold_second_press", 3'b001);
      btn_conta = 1'b1;
      idle(12);
      check_nivel("hold_second_release", 3'b000);
      check_queue_empty("hold_release");
   endtask

   task automatic test_reset_mid();
      int base;
      @(negedge clk);
      btn_conta = 1'b0;
      base = ciclo;
      idle(4);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      n_tests++;
      if ({conta, pausa, para, nivel} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs got %b expected 000000", {conta, pausa, para, nivel});
      end
      expect_pulse(base + 13, 3'b001);
      idle(15);
      check_nivel("reset_mid_hold", 3'b001);
      btn_conta = 1'b1;
      idle(12);
      check_nivel("reset_mid_release", 3'b000);
      check_queue_empty("reset_mid");
   endtask

   task automatic test_random_glitches();
      // Pulses shorter than the confirmation window must never register.
      for (int r = 0; r < 10; r++) begin
         @(negedge clk);
         btn_pausa = 1'b0;
         idle($urandom_range(1, 3));
         btn_pausa = 1'b1;
         idle($urandom_range(2, 5));
      end
      idle(10);
      check_nivel("random_glitches", 3'b000);
      check_queue_empty("random_glitches");
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_glitch();
      test_simultaneous();
      test_pausa_over_conta();
      test_hold_release();
      test_reset_mid();
      test_random_glitches();
      idle(5);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
